// File: rtl/regfile_scoreboard.sv
// Parametrised multi-port register file with a per-register busy scoreboard for RAW hazard detection.
// Reads are combinational (0 cycles); writes and scoreboard updates take effect at the next rising edge.
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             we3,
    input  logic [ADDR_WIDTH-1:0]            wa3,
    input  logic [DATA_WIDTH-1:0]            wd3,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]   ra,
    output logic [NUM_READ*DATA_WIDTH-1:0]   rd,
    output logic [NUM_READ-1:0]              rd_busy,
    input  logic                             iss_valid,
    input  logic [ADDR_WIDTH-1:0]            iss_addr,
    input  logic                             flush,
    output logic [(2**ADDR_WIDTH)-1:0]       busy_vec
);
    localparam int NUM_REGS = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busy_nxt;
    logic                  wr_en;

    assign wr_en = we3 && !(ZERO_REG != 0 && wa3 == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (wr_en) begin
                regs[wa3] <= wd3;
            end
            busy <= busy_nxt;
        end
    end

    // A new issue outranks a same-cycle write-back: the newer producer owns the register.
    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (iss_valid && iss_addr == ADDR_WIDTH'(i)) begin
                    busy_nxt[i] = 1'b1;
                end else if (we3 && wa3 == ADDR_WIDTH'(i)) begin
                    busy_nxt[i] = 1'b0;
                end
            end
        end
        if (ZERO_REG != 0) begin
            busy_nxt[0] = 1'b0;
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        logic                  is_zero;
        logic                  hit;

        assign addr    = ra[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign is_zero = (ZERO_REG != 0) && (addr == '0);
        assign hit     = (BYPASS != 0) && we3 && (addr == wa3) && !is_zero;

        assign rd[k*DATA_WIDTH +: DATA_WIDTH] = is_zero ? '0 : (hit ? wd3 : regs[addr]);
        // Forwarded data is valid now, so the port no longer waits on its producer.
        assign rd_busy[k] = hit ? 1'b0 : busy[addr];
    end

    assign busy_vec = busy;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench: three configurations (default, no bypass, 64-bit/16-reg/3-port without zero register)
// driven from shared stimulus and compared every cycle against an array-based model.
module tb_regfile_scoreboard;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, we, iss, flush;
    logic [4:0]  wa, iss_a, ra0, ra1, ra2;
    logic [63:0] wd;

    logic [63:0]  rd_a, rd_b;
    logic [191:0] rd_c;
    logic [1:0]   rb_a, rb_b;
    logic [2:0]   rb_c;
    logic [31:0]  bv_a, bv_b;
    logic [15:0]  bv_c;

    regfile_scoreboard u_a (
        .clk(clk), .rst(rst), .we3(we), .wa3(wa), .wd3(wd[31:0]), .ra({ra1, ra0}),
        .rd(rd_a), .rd_busy(rb_a), .iss_valid(iss), .iss_addr(iss_a), .flush(flush), .busy_vec(bv_a));

    regfile_scoreboard #(.BYPASS(0)) u_b (
        .clk(clk), .rst(rst), .we3(we), .wa3(wa), .wd3(wd[31:0]), .ra({ra1, ra0}),
        .rd(rd_b), .rd_busy(rb_b), .iss_valid(iss), .iss_addr(iss_a), .flush(flush), .busy_vec(bv_b));

    regfile_scoreboard #(.DATA_WIDTH(64), .ADDR_WIDTH(4), .NUM_READ(3), .ZERO_REG(0)) u_c (
        .clk(clk), .rst(rst), .we3(we), .wa3(wa[3:0]), .wd3(wd), .ra({ra2[3:0], ra1[3:0], ra0[3:0]}),
        .rd(rd_c), .rd_busy(rb_c), .iss_valid(iss), .iss_addr(iss_a[3:0]), .flush(flush), .busy_vec(bv_c));

    int checks = 0;
    int errors = 0;

    logic [63:0] m_reg  [3][32];
    logic [31:0] m_busy [3];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] amask(input int j);
        return (j == 2) ? 5'h0F : 5'h1F;
    endfunction

    function automatic logic [63:0] dmask(input int j);
        return (j == 2) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic logic [4:0] ra_of(input int k);
        return (k == 0) ? ra0 : ((k == 1) ? ra1 : ra2);
    endfunction

    function automatic logic [63:0] act_rd(input int j, input int k);
        case (j)
            0:       return {32'h0, rd_a[k*32 +: 32]};
            1:       return {32'h0, rd_b[k*32 +: 32]};
            default: return rd_c[k*64 +: 64];
        endcase
    endfunction

    function automatic logic act_rb(input int j, input int k);
        case (j)
            0:       return rb_a[k];
            1:       return rb_b[k];
            default: return rb_c[k];
        endcase
    endfunction

    function automatic logic [31:0] act_bv(input int j);
        case (j)
            0:       return bv_a;
            1:       return bv_b;
            default: return {16'h0, bv_c};
        endcase
    endfunction

    // What every port of every instance must show right now, from the architectural state.
    task automatic check_model();
        int          nr;
        logic        zr, bp, zero, hit;
        logic [4:0]  a;
        logic [63:0] exp_rd;
        for (int j = 0; j < 3; j++) begin
            nr = (j == 2) ? 3 : 2;
            zr = (j != 2);
            bp = (j != 1);
            for (int k = 0; k < nr; k++) begin
                a      = ra_of(k) & amask(j);
                zero   = zr && (a == 5'd0);
                hit    = bp && we && ((wa & amask(j)) == a) && !zero;
                exp_rd = zero ? 64'h0 : (hit ? (wd & dmask(j)) : m_reg[j][a]);
                chk($sformatf("rd_i%0d_p%0d", j, k), act_rd(j, k), exp_rd);
                chk($sformatf("rd_busy_i%0d_p%0d", j, k), {63'h0, act_rb(j, k)},
                    {63'h0, (hit ? 1'b0 : m_busy[j][a])});
            end
            chk($sformatf("busy_vec_i%0d", j), {32'h0, act_bv(j)},
                {32'h0, (j == 2) ? (m_busy[j] & 32'h0000_FFFF) : m_busy[j]});
        end
    endtask

    // Architectural effect of one rising edge: later statements override earlier ones.
    task automatic model_edge();
        logic [4:0] w;
        for (int j = 0; j < 3; j++) begin
            if (!rst) begin
                for (int i = 0; i < 32; i++) m_reg[j][i] = 64'h0;
                m_busy[j] = 32'h0;
            end else begin
                w = wa & amask(j);
                if (we && !(j != 2 && w == 5'd0)) m_reg[j][w] = wd & dmask(j);
                if (flush) begin
                    m_busy[j] = 32'h0;
                end else begin
                    if (we)  m_busy[j][w] = 1'b0;
                    if (iss) m_busy[j][iss_a & amask(j)] = 1'b1;
                end
                if (j != 2) m_busy[j][0] = 1'b0;
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        check_model();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    task automatic idle();
        we = 1'b0; iss = 1'b0; flush = 1'b0;
    endtask

    initial begin
        rst = 1'b0; idle(); wa = '0; wd = '0; iss_a = '0; ra0 = '0; ra1 = '0; ra2 = '0;
        @(posedge clk);
        model_edge();
        #1;
        rst = 1'b1;
        settle();
        chk("reset_rd0", {32'h0, rd_a[31:0]}, 64'h0);
        chk("reset_busy_vec", {32'h0, bv_a}, 64'h0);
        tick();

        // Reset after live writes; the write and issue in the reset cycle are discarded.
        we = 1'b1; wa = 5'd5; wd = {$urandom, $urandom}; step();
        wa = 5'd6; wd = {$urandom, $urandom}; iss = 1'b1; iss_a = 5'd6; step();
        rst = 1'b0; wa = 5'd7; wd = {$urandom, $urandom}; iss_a = 5'd8; step();
        rst = 1'b1; idle(); ra0 = 5'd5; ra1 = 5'd6;
        settle();
        chk("post_reset_rd0", {32'h0, rd_a[31:0]}, 64'h0);
        chk("post_reset_rd1", {32'h0, rd_a[63:32]}, 64'h0);
        chk("post_reset_busy_vec", {32'h0, bv_a}, 64'h0);
        tick();

        we = 1'b1; wa = 5'd5; wd = 64'hDEAD_BEEF; step();
        idle(); ra0 = 5'd5; ra1 = 5'd0;
        settle();
        chk("wr_rd_reg5", {32'h0, rd_a[31:0]}, 64'hDEAD_BEEF);
        chk("wr_rd_reg0", {32'h0, rd_a[63:32]}, 64'h0);
        tick();
        we = 1'b1; wa = 5'd0; wd = 64'h1234_5678; step();
        idle(); ra1 = 5'd0;
        settle();
        chk("zero_reg_ignores_write", {32'h0, rd_a[63:32]}, 64'h0);
        chk("no_zero_reg_writable", rd_c[127:64], 64'h1234_5678);
        tick();

        iss = 1'b1; iss_a = 5'd7; step();
        idle(); we = 1'b1; wa = 5'd7; wd = 64'hA5A5_A5A5; ra0 = 5'd7;
        settle();
        chk("bypass_rd0", {32'h0, rd_a[31:0]}, 64'hA5A5_A5A5);
        chk("bypass_rd_busy0", {63'h0, rb_a[0]}, 64'h0);
        chk("nobypass_old_rd0", {32'h0, rd_b[31:0]}, 64'h0);
        chk("nobypass_rd_busy0", {63'h0, rb_b[0]}, 64'h1);
        tick();
        idle();
        settle();
        chk("nobypass_after_edge", {32'h0, rd_b[31:0]}, 64'hA5A5_A5A5);
        chk("wb_clears_7", {63'h0, bv_a[7]}, 64'h0);
        tick();

        iss = 1'b1; iss_a = 5'd9; step();
        idle(); ra0 = 5'd9;
        settle();
        chk("issue_busy9", {63'h0, bv_a[9]}, 64'h1);
        chk("issue_rd_busy9", {63'h0, rb_a[0]}, 64'h1);
        tick();
        step();
        we = 1'b1; wa = 5'd9; wd = 64'h55; step();
        idle();
        settle();
        chk("wb_clears_9", {63'h0, bv_a[9]}, 64'h0);
        tick();
        iss = 1'b1; iss_a = 5'd9; we = 1'b1; wa = 5'd9; step();
        idle();
        settle();
        chk("issue_wins_9", {63'h0, bv_a[9]}, 64'h1);
        tick();

        iss = 1'b1; iss_a = 5'd3; step();
        iss_a = 5'd4; step();
        iss_a = 5'd31; step();
        idle();
        settle();
        chk("busy_before_flush", {32'h0, bv_a}, 64'h8000_0218);
        tick();
        flush = 1'b1; iss = 1'b1; iss_a = 5'd6; we = 1'b1; wa = 5'd3; wd = 64'h1; step();
        idle(); ra0 = 5'd3;
        settle();
        chk("flush_busy_vec", {32'h0, bv_a}, 64'h0);
        chk("flush_write_lands", {32'h0, rd_a[31:0]}, 64'h1);
        tick();

        we = 1'b1; wa = 5'd15; wd = 64'h0123_4567_89AB_CDEF; step();
        wa = 5'd0; wd = 64'hFFFF_FFFF_FFFF_FFFF; step();
        idle(); ra0 = 5'd0; ra1 = 5'd15; ra2 = 5'd15;
        settle();
        chk("wide_rd0", rd_c[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("wide_rd1", rd_c[127:64], 64'h0123_4567_89AB_CDEF);
        chk("wide_rd2", rd_c[191:128], 64'h0123_4567_89AB_CDEF);
        tick();

        for (int n = 0; n < 3000; n++) begin
            rst   = ($urandom_range(0, 63) != 0);
            we    = $urandom_range(0, 1) == 1;
            wa    = 5'($urandom);
            wd    = {$urandom, $urandom};
            iss   = ($urandom_range(0, 2) == 0);
            iss_a = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            flush = ($urandom_range(0, 19) == 0);
            ra0   = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            ra1   = ($urandom_range(0, 3) == 0) ? ra0 : 5'($urandom);
            ra2   = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
